// File: rtl/dpram_fifo_ctrl_if.sv
// Streaming handshakes plus the dual_port_ram port bundle for dpram_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding producer/consumer/RAM side.
interface dpram_fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  ram_we1;
  logic [ADDR_WIDTH-1:0] ram_addr1;
  logic [DATA_WIDTH-1:0] ram_data1;
  logic                  ram_we2;
  logic [ADDR_WIDTH-1:0] ram_addr2;
  logic [DATA_WIDTH-1:0] ram_data2;
  logic [DATA_WIDTH-1:0] ram_out2;

  modport slave (
    input  in_valid, in_data, out_ready, ram_out2,
    output in_ready, out_valid, out_data, count,
           ram_we1, ram_addr1, ram_data1, ram_we2, ram_addr2, ram_data2
  );

  modport master (
    output in_valid, in_data, out_ready, ram_out2,
    input  in_ready, out_valid, out_data, count,
           ram_we1, ram_addr1, ram_data1, ram_we2, ram_addr2, ram_data2
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over an external dual_port_ram: port 1 writes, port 2 reads.
// A prefetch stage plus a 2-entry register buffer hides the RAM read latency for 1 word/cycle.
module dpram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  dpram_fifo_ctrl_if.slave  bus
);
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic [CW-1:0]         count_q,   count_d;
  logic                  pending_q, pending_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q,    buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q,    buf1_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ_after_pop;
  logic [1:0] keep;

  // in_ready depends only on registered count, never on out_ready
  assign bus.in_ready = ~reset & (count_q != DEPTH_C);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (buf_cnt_q != 2'd0) & bus.out_ready;

  // ram_cnt only holds words written on an earlier edge, so no same-cycle read-after-write
  assign occ_after_pop = 3'(buf_cnt_q) + 3'(pending_q) - 3'(pop);
  assign issue         = (ram_cnt_q != '0) && (occ_after_pop < 3'd2);
  assign keep          = buf_cnt_q - 2'(pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q + CW'(push) - CW'(issue);
    count_d   = count_q + CW'(push) - CW'(pop);
    pending_d = issue;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = keep + 2'(pending_q);

    if (push)  wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (issue) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (pop)   buf0_d   = buf1_q;

    // Returning read data lands in the first free slot after this cycle's pop
    if (pending_q) begin
      if (keep == 2'd0) buf0_d = bus.ram_out2;
      else              buf1_d = bus.ram_out2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      buf_cnt_q <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      buf_cnt_q <= buf_cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

  assign bus.out_valid = (buf_cnt_q != 2'd0);
  assign bus.out_data  = buf0_q;
  assign bus.count     = count_q;
  assign bus.ram_we1   = push;
  assign bus.ram_addr1 = wr_ptr_q;
  assign bus.ram_data1 = bus.in_data;
  assign bus.ram_we2   = 1'b0;
  assign bus.ram_addr2 = rd_ptr_q;
  assign bus.ram_data2 = '0;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural dual_port_ram (registered read, old data on collision).
module tb_dpram_fifo_ctrl;
  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we1) mem[bus.ram_addr1] <= bus.ram_data1;
    bus.ram_out2 <= mem[bus.ram_addr2];
  end

  int checks   = 0;
  int failures = 0;
  int exp_wr   = 0;
  int pop_cnt  = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake on the output side must match the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=0x%0h expected=none at %0t", bus.out_data, $time);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      check("count_le_depth", int'(bus.count <= 3'(DEPTH)), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one push for one cycle; records it in the scoreboard if accepted
  task automatic push_word(input logic [DW-1:0] d, output bit acc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    acc = bus.in_ready;
    if (acc) begin
      exp_q.push_back(d);
      check("ram_we1_on_push", bus.ram_we1, 1);
      check("ram_addr1", bus.ram_addr1, exp_wr);
      exp_wr = (exp_wr + 1) % DEPTH;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    @(negedge clk);
    check("drained_out_valid", bus.out_valid, 0);
    check("drained_count", bus.count, 0);
    step();
  endtask

  initial begin
    bit acc;
    int i;
    int cyc;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // 1. reset
    #1;
    check("rst_in_ready_held", bus.in_ready, 0);
    check("rst_out_valid_held", bus.out_valid, 0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_count", bus.count, 0);
    check("rst_ram_we1", bus.ram_we1, 0);
    check("rst_ram_we2", bus.ram_we2, 0);
    step();

    // 2. single word, 3-cycle latency
    bus.out_ready = 1'b1;
    push_word(8'hA5, acc);
    @(negedge clk);
    check("single_addr2", bus.ram_addr2, 0);
    check("single_count_c1", bus.count, 1);
    check("single_valid_c1", bus.out_valid, 0);
    @(negedge clk);
    check("single_valid_c2", bus.out_valid, 0);
    @(negedge clk);
    check("single_valid_c3", bus.out_valid, 1);
    check("single_data_c3", bus.out_data, 8'hA5);
    @(negedge clk);
    check("single_count_c4", bus.count, 0);
    check("single_valid_c4", bus.out_valid, 0);
    step();

    // 3. fill to full, rejected 5th push, drain with no bubble
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_word(8'h10 + 8'(k), acc);
      check("fill_accept", int'(acc), 1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h14;
    @(negedge clk);
    check("full_count", bus.count, 4);
    check("full_in_ready", bus.in_ready, 0);
    check("full_ram_we1", bus.ram_we1, 0);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_no_bubble", bus.out_valid, 1);
      step();
    end
    @(negedge clk);
    check("drain_empty_valid", bus.out_valid, 0);
    check("drain_empty_count", bus.count, 0);
    step();

    // 4. back-to-back streaming across two pointer wraps
    pop_cnt = 0;
    for (int k = 0; k < 10; k++) push_word(8'(k), acc);
    step();
    step();
    check("stream_pops_by_c11", pop_cnt, 9);
    step();
    check("stream_pops_by_c12", pop_cnt, 10);
    check("stream_rd_ptr", bus.ram_addr2, exp_wr);
    wait_drain(10);

    // 5. continuous pushes under toggling backpressure
    i   = 0;
    cyc = 0;
    while (i < 16 && cyc < 200) begin
      bus.out_ready = (cyc % 2 == 0);
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h20 + 8'(i);
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        check("bp_ram_addr1", bus.ram_addr1, exp_wr);
        exp_wr = (exp_wr + 1) % DEPTH;
        i++;
      end else begin
        check("bp_ready_low_only_full", bus.count, 4);
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("bp_all_accepted", i, 16);
    bus.out_ready = 1'b1;
    wait_drain(40);

    // 6. reset while a read is in flight
    bus.out_ready = 1'b0;
    push_word(8'h30, acc);
    push_word(8'h31, acc);
    push_word(8'h32, acc);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_count", bus.count, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    exp_wr = 0;
    step();
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    push_word(8'h40, acc);
    check("postrst_accept", int'(acc), 1);
    wait_drain(10);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
